// File: rtl/rf_pkg.sv
// Shared widths and helpers for the register file.
package rf_pkg;

  localparam int NameBus = 5;
  localparam int NickBus = 5;
  localparam int DataBus = 32;
  localparam int RegNum  = 32;

  typedef logic [NameBus-1:0] name_t;
  typedef logic [NickBus-1:0] nick_t;
  typedef logic [DataBus-1:0] data_t;

  localparam nick_t ZeroNick = '0;

  // True for a register that holds real state (x0 and out-of-range names excluded).
  function automatic logic is_arch(input name_t n, input int regs);
    return (n != '0) && (int'(n) < regs);
  endfunction

endpackage

// File: rtl/rf_if.sv
// Rename, commit and dispatch-read bus of the register file.
interface rf_if;
  import rf_pkg::*;

  logic  iROB_nick_en;
  nick_t iROB_nick;
  name_t iROB_nick_regnm;
  logic  iRF_en;
  name_t iRF_rd_regnm;
  data_t iRF_rd_dt;
  nick_t iRF_rd_nick;
  name_t iDP_rs1_regnm;
  name_t iDP_rs2_regnm;
  data_t oDP_rs1_dt;
  data_t oDP_rs2_dt;
  nick_t oDP_rs1_nick;
  nick_t oDP_rs2_nick;
  nick_t oRF_pend;

  modport master (
    output iROB_nick_en, iROB_nick, iROB_nick_regnm,
    output iRF_en, iRF_rd_regnm, iRF_rd_dt, iRF_rd_nick,
    output iDP_rs1_regnm, iDP_rs2_regnm,
    input  oDP_rs1_dt, oDP_rs2_dt, oDP_rs1_nick, oDP_rs2_nick, oRF_pend
  );

  modport slave (
    input  iROB_nick_en, iROB_nick, iROB_nick_regnm,
    input  iRF_en, iRF_rd_regnm, iRF_rd_dt, iRF_rd_nick,
    input  iDP_rs1_regnm, iDP_rs2_regnm,
    output oDP_rs1_dt, oDP_rs2_dt, oDP_rs1_nick, oDP_rs2_nick, oRF_pend
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational source-read port: stored value/tag, optional commit bypass.
// Optional feature macro: RF_BYPASS_EN (forward same-cycle matching commit data).
module rf_read_port
  import rf_pkg::*;
#(
  parameter int RF_REGS = RegNum
) (
  input  logic  rst_n,
  input  logic  i_rdy,
  input  name_t i_regnm,
  input  data_t i_value [RF_REGS],
  input  nick_t i_tag   [RF_REGS],
  input  logic  i_cm_en,
  input  nick_t i_cm_nick,
  input  data_t i_cm_dt,
  output data_t o_dt,
  output nick_t o_nick
);

  logic w_valid;
  assign w_valid = rst_n && is_arch(i_regnm, RF_REGS);

`ifndef RF_BYPASS_EN
  // Commit inputs only matter when forwarding is built in.
  logic w_unused;
  assign w_unused = ^{i_rdy, i_cm_en, i_cm_nick, i_cm_dt};
`endif

  // Select the named register; x0 and reset read as zero.
  always_comb begin
    o_dt   = '0;
    o_nick = ZeroNick;
    if (w_valid) begin
      o_dt   = i_value[i_regnm];
      o_nick = i_tag[i_regnm];
`ifdef RF_BYPASS_EN
      // A commit of the pending producer this cycle makes the value ready now.
      if (i_rdy && i_cm_en && (o_nick != ZeroNick) && (o_nick == i_cm_nick)) begin
        o_dt   = i_cm_dt;
        o_nick = ZeroNick;
      end
`endif
    end
  end

endmodule

// File: rtl/rf.sv
// Architectural register file with rename tags (pending-producer nicks).
// Optional feature macro: RF_BYPASS_EN (see rf_read_port).
module rf
  import rf_pkg::*;
#(
  parameter int RF_REGS = RegNum
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rdy,
  input  logic clr,
  rf_if.slave  bus
);

  data_t r_value [RF_REGS];
  nick_t r_tag   [RF_REGS];
  nick_t r_pend;

  data_t w_value_next [RF_REGS];
  nick_t w_tag_next   [RF_REGS];
  logic [RF_REGS-1:0] w_busy;
  logic [5:0] w_pend_cnt;
  nick_t w_pend_sat;

  // Next state: commit first, then flush or rename, so a same-register rename wins the tag.
  always_comb begin
    for (int i = 0; i < RF_REGS; i++) begin
      w_value_next[i] = r_value[i];
      w_tag_next[i]   = r_tag[i];
    end
    if (bus.iRF_en && is_arch(bus.iRF_rd_regnm, RF_REGS)) begin
      w_value_next[bus.iRF_rd_regnm] = bus.iRF_rd_dt;
      if (r_tag[bus.iRF_rd_regnm] == bus.iRF_rd_nick)
        w_tag_next[bus.iRF_rd_regnm] = ZeroNick;
    end
    if (clr) begin
      for (int i = 0; i < RF_REGS; i++)
        w_tag_next[i] = ZeroNick;
    end else if (bus.iROB_nick_en && is_arch(bus.iROB_nick_regnm, RF_REGS)) begin
      w_tag_next[bus.iROB_nick_regnm] = bus.iROB_nick;
    end
  end

  // Per-register pending flag of the next state.
  genvar gi;
  generate
    for (gi = 0; gi < RF_REGS; gi++) begin : g_busy
      assign w_busy[gi] = (w_tag_next[gi] != ZeroNick);
    end
  endgenerate

  // Count pending registers; the count can never legitimately exceed 31.
  always_comb begin
    w_pend_cnt = '0;
    for (int i = 0; i < RF_REGS; i++)
      w_pend_cnt = w_pend_cnt + 6'(w_busy[i]);
    w_pend_sat = (w_pend_cnt > 6'd31) ? 5'd31 : w_pend_cnt[4:0];
  end

  // State update: async clear, otherwise advance only while rdy is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_REGS; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= ZeroNick;
      end
      r_pend <= ZeroNick;
    end else if (rdy) begin
      for (int i = 0; i < RF_REGS; i++) begin
        r_value[i] <= w_value_next[i];
        r_tag[i]   <= w_tag_next[i];
      end
      r_pend <= w_pend_sat;
    end
  end

  assign bus.oRF_pend = r_pend;

  rf_read_port #(.RF_REGS(RF_REGS)) u_rs1 (
    .rst_n    (rst_n),
    .i_rdy    (rdy),
    .i_regnm  (bus.iDP_rs1_regnm),
    .i_value  (r_value),
    .i_tag    (r_tag),
    .i_cm_en  (bus.iRF_en),
    .i_cm_nick(bus.iRF_rd_nick),
    .i_cm_dt  (bus.iRF_rd_dt),
    .o_dt     (bus.oDP_rs1_dt),
    .o_nick   (bus.oDP_rs1_nick)
  );

  rf_read_port #(.RF_REGS(RF_REGS)) u_rs2 (
    .rst_n    (rst_n),
    .i_rdy    (rdy),
    .i_regnm  (bus.iDP_rs2_regnm),
    .i_value  (r_value),
    .i_tag    (r_tag),
    .i_cm_en  (bus.iRF_en),
    .i_cm_nick(bus.iRF_rd_nick),
    .i_cm_dt  (bus.iRF_rd_dt),
    .o_dt     (bus.oDP_rs2_dt),
    .o_nick   (bus.oDP_rs2_nick)
  );

endmodule

// File: doc/rf.md
RF -- requirements
Module: rf

Interface
REQ-001 SHALL have parameter RF_REGS, default 32: architectural register count, 5-bit names.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; low freezes all state.
- clr  in  1  ROB flush (misprediction).
- iROB_nick_en  in  1  rename request.
- iROB_nick  in  5  new tag, 1..31.
- iROB_nick_regnm  in  5  renamed rd.
- iRF_en  in  1  ROB commit valid.
- iRF_rd_regnm  in  5  commit rd.
- iRF_rd_dt  in  32  commit data.
- iRF_rd_nick  in  5  committing tag.
- iDP_rs1_regnm, iDP_rs2_regnm  in  5  each  dispatch source names.
- oDP_rs1_dt, oDP_rs2_dt  out  32 each  source values.
- oDP_rs1_nick, oDP_rs2_nick  out  5 each  pending tag; 0 = value ready.
- oRF_pend  out  5  count of registers with nonzero tag.

Function
REQ-003 SHALL hold per register a 32-bit value and a 5-bit tag; tag 0 = no pending producer.
REQ-004 SHALL treat x0 as constant: reads return dt 0/nick 0; renames and commits to x0 ignored.
REQ-005 SHALL make source reads combinational, zero latency: output stored value and tag of the named register.
REQ-006 SHALL, on rising edge with rdy=1 and iROB_nick_en=1, set tag[iROB_nick_regnm] <= iROB_nick.
REQ-007 SHALL, on rising edge with rdy=1 and iRF_en=1, write value[iRF_rd_regnm] <= iRF_rd_dt unconditionally.
REQ-008 SHALL clear the committed register's tag only if it equals iRF_rd_nick; a newer tag is kept.
REQ-009 SHALL, for rename and commit to the same register in one cycle, write the value and leave tag = new iROB_nick.
REQ-010 SHALL let a same-cycle read of a register being renamed see pre-rename state (sources read before own rd).
REQ-011 SHALL, on clr=1 with rdy=1, set all tags to 0 at the edge, ignore same-cycle rename, still perform same-cycle commit data write.
REQ-012 SHALL change no state when rdy=0; reads remain live.
REQ-013 SHALL keep oRF_pend registered: equal to the number of nonzero tags after each edge (+1 on rename of a tag-0 reg, -1 on matching commit clear, net 0 for both on one reg, 0 after clr).
REQ-014 SHALL never assert oRF_pend above 31.

Reset
REQ-015 SHALL, while rst_n=0, asynchronously force all values to 0, all tags to 0, oRF_pend to 0.
REQ-016 SHALL drive all read outputs to 0 during reset.
REQ-017 SHALL abandon any rename/commit in flight when reset asserts mid-cycle; first post-reset edge acts on fresh inputs only.

Configuration
REQ-018 SHALL support macro RF_BYPASS_EN: when defined, a read whose register has tag == iRF_rd_nick with iRF_en=1 and rdy=1 returns iRF_rd_dt and nick 0 same cycle.
REQ-019 SHALL, without RF_BYPASS_EN, return stored value/tag; committed value visible from the next cycle.

Structure
REQ-020 SHALL take NameBus, NickBus, DataBus, RegNum and ZeroNick (0) from shared config.v.
REQ-021 SHALL implement the read/bypass mux as sub-module rf_read_port, instantiated twice.

Verification
REQ-022 Reset, read x5 -> dt 0, nick 0, oRF_pend 0.
REQ-023 Rename x3->nick 7, next cycle commit x3/nick 7/dt 0xDEADBEEF -> read x3 dt 0xDEADBEEF, nick 0, oRF_pend 0.
REQ-024 Rename x3->7, rename x3->9, commit x3/nick 7/dt 0x11 -> x3 dt 0x11, nick 9, oRF_pend 1.
REQ-025 Same cycle rename x4->12 and commit x4/nick 5/dt 0x22 (tag was 5) -> x4 nick 12, dt 0x22.
REQ-026 Renames x1->2, x2->3; clr with rename x6->4 -> all nicks 0, x6 not renamed, oRF_pend 0.
REQ-027 With RF_BYPASS_EN: x8 tag 10, commit nick 10/dt 0x55 -> same-cycle read x8 dt 0x55, nick 0; without: nick 10.
